// File: rtl/boot_loader_if.sv
// Word stream into the boot loader: one word moves on each cycle with s_valid && s_ready.
// The source owns s_valid/s_data, the loader owns s_ready; there is no added latency.
interface boot_loader_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/boot_loader.sv
// Loads header, instruction image and data image from a stream into the BRAMs, then releases the CPU.
// Each write strobe follows its accepted word by 1 cycle; s_valid low stalls the load indefinitely.
module boot_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    boot_loader_if.slave          strm,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic                  d_bram_init_done,
    output logic                  pc_stall,
    output logic                  cpu_rst,
    output logic                  i_r_enb,
    output logic                  rd_enbl,
    output logic                  busy,
    output logic                  load_err,
    output logic [31:0]           run_cycles
);
    localparam logic [CNT_WIDTH:0] MAX_WORDS = (CNT_WIDTH+1)'(2 ** (ADDR_WIDTH-2));

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_INSTR, S_DATA, S_RUN, S_ERR
    } state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  icnt;
    logic [CNT_WIDTH-1:0]  dcnt;
    logic [ADDR_WIDTH-3:0] idx;

    logic                  xfer;
    logic [CNT_WIDTH-1:0]  hdr_icnt;
    logic [CNT_WIDTH-1:0]  hdr_dcnt;
    logic                  hdr_bad;
    logic                  last_instr;
    logic                  last_data;
    logic                  can_start;

    assign xfer       = strm.s_valid && strm.s_ready;
    assign hdr_icnt   = strm.s_data[2*CNT_WIDTH-1:CNT_WIDTH];
    assign hdr_dcnt   = strm.s_data[CNT_WIDTH-1:0];
    assign hdr_bad    = (hdr_icnt == '0) || ({1'b0, hdr_icnt} > MAX_WORDS) ||
                        ({1'b0, hdr_dcnt} > MAX_WORDS);
    assign last_instr = (CNT_WIDTH'(idx) == icnt - CNT_WIDTH'(1));
    assign last_data  = (CNT_WIDTH'(idx) == dcnt - CNT_WIDTH'(1));
    assign can_start  = start && (state == S_IDLE || state == S_RUN || state == S_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            icnt             <= '0;
            dcnt             <= '0;
            idx              <= '0;
            strm.s_ready     <= 1'b0;
            i_w_addr         <= '0;
            i_w_dat          <= '0;
            i_w_enb          <= 1'b0;
            d_w_addr         <= '0;
            d_w_dat          <= '0;
            d_w_enb          <= 1'b0;
            d_bram_init_done <= 1'b0;
            pc_stall         <= 1'b1;
            cpu_rst          <= 1'b1;
            i_r_enb          <= 1'b0;
            rd_enbl          <= 1'b0;
            busy             <= 1'b0;
            load_err         <= 1'b0;
            run_cycles       <= '0;
        end else begin
            i_w_enb <= 1'b0;
            d_w_enb <= 1'b0;
            if (can_start) begin
                // (Re)load: park the CPU and hand the data port back before any word arrives.
                state            <= S_HDR;
                strm.s_ready     <= 1'b1;
                busy             <= 1'b1;
                load_err         <= 1'b0;
                pc_stall         <= 1'b1;
                cpu_rst          <= 1'b1;
                i_r_enb          <= 1'b0;
                rd_enbl          <= 1'b0;
                d_bram_init_done <= 1'b0;
                run_cycles       <= '0;
            end else begin
                case (state)
                    S_HDR: begin
                        if (xfer) begin
                            icnt <= hdr_icnt;
                            dcnt <= hdr_dcnt;
                            idx  <= '0;
                            if (hdr_bad) begin
                                state        <= S_ERR;
                                strm.s_ready <= 1'b0;
                                busy         <= 1'b0;
                                load_err     <= 1'b1;
                            end else begin
                                state <= S_INSTR;
                            end
                        end
                    end
                    S_INSTR: begin
                        if (xfer) begin
                            i_w_addr <= {idx, 2'b00};
                            i_w_dat  <= strm.s_data;
                            i_w_enb  <= 1'b1;
                            if (last_instr) begin
                                idx <= '0;
                                if (dcnt != '0) begin
                                    state <= S_DATA;
                                end else begin
                                    state        <= S_RUN;
                                    strm.s_ready <= 1'b0;
                                    busy         <= 1'b0;
                                end
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (xfer) begin
                            d_w_addr <= {idx, 2'b00};
                            d_w_dat  <= strm.s_data;
                            d_w_enb  <= 1'b1;
                            if (last_data) begin
                                idx          <= '0;
                                state        <= S_RUN;
                                strm.s_ready <= 1'b0;
                                busy         <= 1'b0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        // Release lands one cycle after RUN entry, so the final write strobe
                        // always completes while the CPU is still parked.
                        pc_stall         <= 1'b0;
                        cpu_rst          <= 1'b0;
                        i_r_enb          <= 1'b1;
                        rd_enbl          <= 1'b1;
                        d_bram_init_done <= 1'b1;
                        if (run_cycles != '1) begin
                            run_cycles <= run_cycles + 32'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: nominal, backpressured, bad-header, dcnt=0, reload and async-reset loads.
module tb_boot_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  i_w_addr, d_w_addr;
    logic [31:0] i_w_dat, d_w_dat, run_cycles;
    logic        i_w_enb, d_w_enb, d_bram_init_done, pc_stall, cpu_rst;
    logic        i_r_enb, rd_enbl, busy, load_err;

    int checks = 0;
    int errors = 0;

    boot_loader_if #(.DATA_WIDTH(32)) strm ();

    boot_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .strm(strm),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
        .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall), .cpu_rst(cpu_rst),
        .i_r_enb(i_r_enb), .rd_enbl(rd_enbl), .busy(busy), .load_err(load_err),
        .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // AND/OR R-type program image and its data words
    logic [31:0] prog [0:5] = '{32'h0020_f2b3, 32'h0020_e333, 32'h0011_73b3,
                                32'h0020_e433, 32'h0011_f4b3, 32'h0000_006f};
    logic [31:0] data_img [0:1] = '{32'h0000_0003, 32'h0000_0001};

    logic [9:0]  i_addr_q [$];
    logic [31:0] i_dat_q  [$];
    logic [9:0]  d_addr_q [$];
    logic [31:0] d_dat_q  [$];
    logic        bad_overlap = 1'b0;
    logic        bad_init    = 1'b0;
    logic        bad_release = 1'b0;
    logic        busy_drop   = 1'b0;

    always @(negedge clk) begin
        if (i_w_enb) begin
            i_addr_q.push_back(i_w_addr);
            i_dat_q.push_back(i_w_dat);
        end
        if (d_w_enb) begin
            d_addr_q.push_back(d_w_addr);
            d_dat_q.push_back(d_w_dat);
        end
        if (i_w_enb && d_w_enb) bad_overlap = 1'b1;
        if (d_w_enb && d_bram_init_done) bad_init = 1'b1;
        if ((i_w_enb || d_w_enb) && !pc_stall) bad_release = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input bit gap);
        int n = 0;
        if (gap) begin
            @(negedge clk) strm.s_valid = 1'b0;
            if (!busy) busy_drop = 1'b1;
        end
        @(negedge clk);
        strm.s_valid = 1'b1;
        strm.s_data  = w;
        while (!strm.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic wait_run();
        int n = 0;
        while (pc_stall && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("run_reached_pc_stall", 32'(pc_stall), 32'd0);
    endtask

    task automatic load_words(input logic [31:0] hdr, input int n_i, input int n_d, input bit gap);
        int ib = i_addr_q.size();
        int db = d_addr_q.size();
        send(hdr, gap);
        for (int k = 0; k < n_i; k++) send(prog[k], gap);
        for (int k = 0; k < n_d; k++) send(data_img[k], gap);
        @(negedge clk) strm.s_valid = 1'b0;
        chk("busy_after_last", 32'(busy), 32'd0);
        chk("final_strobe", 32'((n_d > 0) ? d_w_enb : i_w_enb), 32'd1);
        chk("init_done_during_last", 32'(d_bram_init_done), 32'd0);
        wait_run();
        chk("run_init_done", 32'(d_bram_init_done), 32'd1);
        chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("run_rd_enables", 32'({i_r_enb, rd_enbl}), 32'd3);
        chk("i_write_count", 32'(i_addr_q.size() - ib), 32'(n_i));
        chk("d_write_count", 32'(d_addr_q.size() - db), 32'(n_d));
        for (int k = 0; k < n_i; k++) begin
            if (ib + k < i_addr_q.size()) begin
                chk("i_addr", 32'(i_addr_q[ib+k]), 32'(k * 4));
                chk("i_dat", i_dat_q[ib+k], prog[k]);
            end
        end
        for (int k = 0; k < n_d; k++) begin
            if (db + k < d_addr_q.size()) begin
                chk("d_addr", 32'(d_addr_q[db+k]), 32'(k * 4));
                chk("d_dat", d_dat_q[db+k], data_img[k]);
            end
        end
    endtask

    task automatic bad_header(input logic [31:0] hdr);
        int ib = i_addr_q.size();
        int db = d_addr_q.size();
        pulse_start();
        chk("start_clears_err", 32'(load_err), 32'd0);
        send(hdr, 1'b0);
        @(negedge clk) strm.s_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("err_load_err", 32'(load_err), 32'd1);
        chk("err_cpu_held", 32'({pc_stall, cpu_rst}), 32'd3);
        chk("err_idle_port", 32'({busy, strm.s_ready}), 32'd0);
        chk("err_no_strobes", 32'((i_addr_q.size() - ib) + (d_addr_q.size() - db)), 32'd0);
    endtask

    initial begin
        strm.s_valid = 1'b0;
        strm.s_data  = '0;

        repeat (2) @(negedge clk);
        chk("rst_pc_stall", 32'(pc_stall), 32'd1);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_ready_busy", 32'({strm.s_ready, busy, load_err}), 32'd0);
        chk("rst_strobes", 32'({i_w_enb, d_w_enb, d_bram_init_done, i_r_enb, rd_enbl}), 32'd0);
        chk("rst_run_cycles", run_cycles, 32'd0);
        rst = 1'b0;

        // Nominal load, then count 20 RUN cycles
        pulse_start();
        chk("hdr_busy", 32'({busy, strm.s_ready}), 32'd3);
        load_words(32'h0006_0002, 6, 2, 1'b0);
        chk("run_cycles_first", run_cycles, 32'd1);
        repeat (19) @(negedge clk);
        chk("run_cycles_20", run_cycles, 32'd20);

        // Reload from RUN with s_valid toggling every other cycle
        pulse_start();
        chk("reload_pc_stall", 32'(pc_stall), 32'd1);
        chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reload_run_cycles", run_cycles, 32'd0);
        chk("reload_init_done", 32'(d_bram_init_done), 32'd0);
        load_words(32'h0006_0002, 6, 2, 1'b1);
        chk("bp_busy_held", 32'(busy_drop), 32'd0);

        bad_header(32'h0000_0005);
        bad_header(32'h0101_0000);

        // dcnt = 0: straight to RUN after the third instruction word
        pulse_start();
        chk("err_cleared", 32'(load_err), 32'd0);
        load_words(32'h0003_0000, 3, 0, 1'b0);

        // Async reset after two instruction words
        pulse_start();
        send(32'h0006_0002, 1'b0);
        send(prog[0], 1'b0);
        send(prog[1], 1'b0);
        #2 rst = 1'b1;
        strm.s_valid = 1'b0;
        #1;
        chk("arst_ready", 32'(strm.s_ready), 32'd0);
        chk("arst_cpu_held", 32'({pc_stall, cpu_rst}), 32'd3);
        chk("arst_strobe", 32'({i_w_enb, d_w_enb, busy}), 32'd0);
        chk("arst_addr", 32'(i_w_addr), 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_arst_idle", 32'({strm.s_ready, busy, pc_stall}), 32'd1);

        chk("strobe_overlap", 32'(bad_overlap), 32'd0);
        chk("strobe_with_init_done", 32'(bad_init), 32'd0);
        chk("strobe_with_cpu_running", 32'(bad_release), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
